branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- EX-stage counterpart of the fetch-side branch predictor.
- Decode pushes each branch's prediction (PC, predicted direction, predicted target) into an in-order queue. When EX resolves the branch, the block pops the matching entry and compares it with the actual outcome.
- On a mismatch it redirects fetch and flushes wrong-path state. It also emits a one-cycle update record for the predictor table and keeps resolution statistics.

Parameters:
DEPTH, 4, number of in-flight branch entries between ID and EX (power of 2, at least 2)
AW, 16, PC/address width
FLUSH_CYCLES, 2, cycles after a redirect during which decode pushes and EX resolves are ignored (at least 1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
dec_push  in  1  decode has a branch; push its prediction
dec_pc  in  AW  PC of the decoded branch
dec_pred_taken  in  1  predictor said taken
dec_pred_target  in  AW  predicted target; don't-care if not taken
ex_valid  in  1  EX resolves a branch this cycle
ex_pc  in  AW  PC of the resolving branch
ex_taken  in  1  actual outcome (ALU result zero)
ex_target  in  AW  actual branch address
ex_pc_plus  in  AW  fall-through PC
q_full  out  1  queue full; decode must stall
q_empty  out  1  queue empty
change_PC  out  1  one-cycle redirect strobe
next_PC  out  AW  redirect address, valid while change_PC is high
flush  out  1  high while the redirect/drain sequence runs
upd_valid  out  1  one-cycle predictor update strobe
upd_pc  out  AW  update PC
upd_taken  out  1  actual outcome for the predictor history
upd_target  out  AW  actual target
mispredict_cnt  out  16  saturating mispredict count
branch_cnt  out  16  saturating resolved-branch count
seq_err  out  1  sticky: ex_pc did not match the head entry, or a push was dropped while full

Behaviour:
- Reset (rst=1 at a clock edge): queue emptied (rd/wr pointers 0), state IDLE, and all outputs 0 except q_empty=1. Counters and seq_err are cleared. Reset mid-sequence abandons any redirect/drain immediately.
- Queue: circular buffer, DEPTH entries, pointers carry one extra wrap bit. q_full/q_empty are derived from the registered pointers only.
- Push: occurs when dec_push=1, state is IDLE, and either !q_full or a pop happens the same cycle. A push while full with no pop is dropped and sets seq_err.
- Pop: occurs when ex_valid=1 and state is IDLE.
  - Empty queue: the head is treated as {pc=ex_pc, taken=0, target=0}, i.e. a predictor miss.
  - Head PC differs from ex_pc: seq_err is set and the pop is forced to resolve as a mispredict.
- Mispredict condition: head.taken != ex_taken, or (ex_taken=1 and head.target != ex_target), or a PC mismatch.
- Latency: all outputs are registered. Resolving in cycle N produces its outputs in cycle N+1.
  - upd_valid=1 for exactly one cycle per accepted pop, carrying upd_pc=ex_pc, upd_taken=ex_taken, upd_target=ex_target.
  - branch_cnt increments per accepted pop; mispredict_cnt increments per mispredict. Both saturate at 0xFFFF.
- FSM:
  - IDLE: on an accepted pop with a mispredict, go to REDIRECT.
  - REDIRECT: exactly one cycle.
    - change_PC=1, next_PC = ex_taken ? ex_target : ex_pc_plus (value captured at resolve), flush=1.
    - The queue is cleared (all entries are wrong-path), including any push accepted in the resolve cycle.
    - Go to DRAIN with drain counter = FLUSH_CYCLES-1; if FLUSH_CYCLES=1, go directly to IDLE.
  - DRAIN: flush=1; dec_push and ex_valid are ignored (no push, no pop, no update, no counting). Counter decrements; return to IDLE when it reaches 0.
- Correct prediction: no change_PC and no flush; the pop completes normally.
- Simultaneous push and pop in IDLE: both take effect. Occupancy is unchanged; a full queue stays full with no drop.
- next_PC reads 0 whenever change_PC=0.

Test Plan:
1. Reset, then push {pc=0x0010, taken=1, tgt=0x0040}; resolve ex_pc=0x0010, taken=1, tgt=0x0040 -> next cycle upd_valid=1, change_PC=0, flush=0, branch_cnt=1, mispredict_cnt=0, q_empty=1.
2. Push {0x0020, taken=0}; resolve taken=1, tgt=0x0080 -> change_PC=1 with next_PC=0x0080 for 1 cycle, flush high for 2 cycles, mispredict_cnt=1. A dec_push issued during DRAIN is ignored, so the queue stays empty afterwards.
3. Push {0x0030, taken=1, tgt=0x0050}; resolve taken=0, ex_pc_plus=0x0031 -> next_PC=0x0031. Two younger pushes made before the resolve are discarded: q_empty=1 after REDIRECT.
4. Push 4 entries -> q_full=1; a 5th push alone is dropped and sets seq_err. A push plus correct pop in the same cycle keeps q_full=1 with the head advanced.
5. ex_valid with an empty queue, ex_taken=1, tgt=0x0100 -> treated as a miss: redirect to 0x0100 and upd_valid=1. Also, ex_pc=0x0099 against head pc 0x0010 -> seq_err=1 plus a redirect.
6. Assert rst during DRAIN -> the next cycle shows flush=0, q_empty=1, counters=0, seq_err=0, state IDLE. Separately, drive 0xFFFF+ mispredicts -> mispredict_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: in-order prediction queue, mispredict redirect/flush
// sequencing, predictor update strobe and saturating resolution statistics.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | accepting decode pushes and EX resolves
// REDIRECT | one-cycle change_PC strobe; queue already emptied of wrong path
// DRAIN    | flush held; pushes and resolves ignored until counter expires
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int AW           = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_push,
  input  logic [AW-1:0]    dec_pc,
  input  logic             dec_pred_taken,
  input  logic [AW-1:0]    dec_pred_target,
  input  logic             ex_valid,
  input  logic [AW-1:0]    ex_pc,
  input  logic             ex_taken,
  input  logic [AW-1:0]    ex_target,
  input  logic [AW-1:0]    ex_pc_plus,
  output logic             q_full,
  output logic             q_empty,
  output logic             change_PC,
  output logic [AW-1:0]    next_PC,
  output logic             flush,
  output logic             upd_valid,
  output logic [AW-1:0]    upd_pc,
  output logic             upd_taken,
  output logic [AW-1:0]    upd_target,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic             seq_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_drain_cnt, w_drain_cnt_nxt;

  logic [AW-1:0]   r_q_pc    [DEPTH];
  logic            r_q_taken [DEPTH];
  logic [AW-1:0]   r_q_tgt   [DEPTH];
  logic [PW:0]     r_wr_ptr, r_rd_ptr;

  logic            r_upd_valid, r_upd_taken, r_seq_err;
  logic [AW-1:0]   r_upd_pc, r_upd_tgt, r_next_pc;
  logic [CNT_W-1:0] r_misp_cnt, r_br_cnt;

  logic            w_empty, w_full, w_idle, w_pop, w_push, w_drop;
  logic [AW-1:0]   w_head_pc, w_head_tgt;
  logic            w_head_taken, w_pc_mis, w_mis, w_redirect;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_idle  = (r_state == S_IDLE);
  assign w_pop   = ex_valid && w_idle;
  assign w_push  = dec_push && w_idle && (!w_full || w_pop);
  assign w_drop  = dec_push && w_idle && w_full && !w_pop;

  // An empty queue resolves against a synthetic not-taken entry at ex_pc.
  assign w_head_pc    = w_empty ? ex_pc : r_q_pc[r_rd_ptr[PW-1:0]];
  assign w_head_taken = w_empty ? 1'b0  : r_q_taken[r_rd_ptr[PW-1:0]];
  assign w_head_tgt   = w_empty ? '0    : r_q_tgt[r_rd_ptr[PW-1:0]];

  assign w_pc_mis   = (w_head_pc != ex_pc);
  assign w_mis      = (w_head_taken != ex_taken) ||
                      (ex_taken && (w_head_tgt != ex_target)) || w_pc_mis;
  assign w_redirect = w_pop && w_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = DW'(FLUSH_CYCLES - 1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        w_drain_cnt_nxt = r_drain_cnt - 1'b1;
        if (r_drain_cnt <= DW'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Everything still queued on a mispredict is younger, hence wrong-path.
  always_ff @(posedge clk) begin
    if (rst || w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)             r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop && !w_empty)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_pc[r_wr_ptr[PW-1:0]]    <= dec_pc;
      r_q_taken[r_wr_ptr[PW-1:0]] <= dec_pred_taken;
      r_q_tgt[r_wr_ptr[PW-1:0]]   <= dec_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_valid <= 1'b0;
      r_upd_pc    <= '0;
      r_upd_taken <= 1'b0;
      r_upd_tgt   <= '0;
      r_next_pc   <= '0;
      r_misp_cnt  <= '0;
      r_br_cnt    <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_upd_valid <= w_pop;
      r_upd_pc    <= w_pop ? ex_pc     : '0;
      r_upd_taken <= w_pop && ex_taken;
      r_upd_tgt   <= w_pop ? ex_target : '0;
      r_next_pc   <= w_redirect ? (ex_taken ? ex_target : ex_pc_plus) : '0;
      if (w_pop && (r_br_cnt != '1))        r_br_cnt   <= r_br_cnt + 1'b1;
      if (w_redirect && (r_misp_cnt != '1)) r_misp_cnt <= r_misp_cnt + 1'b1;
      if ((w_pop && w_pc_mis) || w_drop)    r_seq_err  <= 1'b1;
    end
  end

  assign q_full         = w_full;
  assign q_empty        = w_empty;
  assign change_PC      = (r_state == S_REDIRECT);
  assign next_PC        = r_next_pc;
  assign flush          = (r_state != S_IDLE);
  assign upd_valid      = r_upd_valid;
  assign upd_pc         = r_upd_pc;
  assign upd_taken      = r_upd_taken;
  assign upd_target     = r_upd_tgt;
  assign mispredict_cnt = r_misp_cnt;
  assign branch_cnt     = r_br_cnt;
  assign seq_err        = r_seq_err;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: per-cycle vector table plus hand-written
// reset-in-drain, PC-mismatch, empty-queue and counter-saturation sequences.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_push, dec_pred_taken, ex_valid, ex_taken;
  logic [15:0] dec_pc, dec_pred_target, ex_pc, ex_target, ex_pc_plus;
  logic        q_full, q_empty, change_PC, flush, upd_valid, upd_taken, seq_err;
  logic [15:0] next_PC, upd_pc, upd_target, mispredict_cnt, branch_cnt;

  // Second instance: narrow counters and single-cycle flush
  logic        s_rst, s_exv, s_ext, s_zero;
  logic [15:0] s_expc, s_extgt, s_zero16;
  logic        s_full, s_empty, s_chg, s_flush, s_uv, s_ut, s_serr;
  logic [15:0] s_npc, s_upc, s_utgt;
  logic [2:0]  s_mc, s_bc;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(4), .AW(16), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dec_push(dec_push), .dec_pc(dec_pc),
    .dec_pred_taken(dec_pred_taken), .dec_pred_target(dec_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pc_plus(ex_pc_plus), .q_full(q_full),
    .q_empty(q_empty), .change_PC(change_PC), .next_PC(next_PC), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .mispredict_cnt(mispredict_cnt),
    .branch_cnt(branch_cnt), .seq_err(seq_err)
  );

  branch_resolver #(.DEPTH(4), .AW(16), .FLUSH_CYCLES(1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(s_rst), .dec_push(s_zero), .dec_pc(s_zero16),
    .dec_pred_taken(s_zero), .dec_pred_target(s_zero16),
    .ex_valid(s_exv), .ex_pc(s_expc), .ex_taken(s_ext),
    .ex_target(s_extgt), .ex_pc_plus(s_zero16), .q_full(s_full),
    .q_empty(s_empty), .change_PC(s_chg), .next_PC(s_npc), .flush(s_flush),
    .upd_valid(s_uv), .upd_pc(s_upc), .upd_taken(s_ut),
    .upd_target(s_utgt), .mispredict_cnt(s_mc),
    .branch_cnt(s_bc), .seq_err(s_serr)
  );

  typedef struct {
    logic push; logic [15:0] pc; logic pt; logic [15:0] ptgt;
    logic exv; logic [15:0] expc; logic ext; logic [15:0] extgt; logic [15:0] explus;
    logic full; logic empty; logic chg; logic [15:0] npc; logic fl;
    logic uv; logic [15:0] upc; logic ut; logic [15:0] utgt;
    logic [15:0] mc; logic [15:0] bc; logic serr;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic push, input logic [15:0] pc, input logic pt,
                       input logic [15:0] ptgt, input logic exv, input logic [15:0] expc,
                       input logic ext, input logic [15:0] extgt, input logic [15:0] explus);
    dec_push = push; dec_pc = pc; dec_pred_taken = pt; dec_pred_target = ptgt;
    ex_valid = exv; ex_pc = expc; ex_taken = ext; ex_target = extgt; ex_pc_plus = explus;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    //        push  pc       pt    ptgt      exv   expc     ext   extgt     explus    full  empty chg   npc       fl    uv    upc       ut    utgt      mc     bc     serr
    vt[0]  = '{1'b1,16'h0010,1'b1,16'h0040, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd0,16'd0,1'b0};
    vt[1]  = '{1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0010,1'b1,16'h0040,16'h0011, 1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0010,1'b1,16'h0040,16'd0,16'd1,1'b0};
    vt[2]  = '{1'b1,16'h0020,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd0,16'd1,1'b0};
    vt[3]  = '{1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0020,1'b1,16'h0080,16'h0021, 1'b0,1'b1,1'b1,16'h0080,1'b1,1'b1,16'h0020,1'b1,16'h0080,16'd1,16'd2,1'b0};
    vt[4]  = '{1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0,16'h0000,16'd1,16'd2,1'b0};
    vt[5]  = '{1'b1,16'h0022,1'b1,16'h0090, 1'b1,16'h0022,1'b1,16'h0090,16'h0023, 1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd1,16'd2,1'b0};
    vt[6]  = '{1'b1,16'h0030,1'b1,16'h0050, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd1,16'd2,1'b0};
    vt[7]  = '{1'b1,16'h0034,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd1,16'd2,1'b0};
    vt[8]  = '{1'b1,16'h0038,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd1,16'd2,1'b0};
    vt[9]  = '{1'b1,16'h003C,1'b0,16'h0000, 1'b1,16'h0030,1'b0,16'h0077,16'h0031, 1'b0,1'b1,1'b1,16'h0031,1'b1,1'b1,16'h0030,1'b0,16'h0077,16'd2,16'd3,1'b0};
    vt[10] = '{1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b0,16'h0000,16'd2,16'd3,1'b0};
    vt[11] = '{1'b0,16'h0000,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd2,16'd3,1'b0};
    vt[12] = '{1'b1,16'h0100,1'b1,16'h0200, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd2,16'd3,1'b0};
    vt[13] = '{1'b1,16'h0104,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd2,16'd3,1'b0};
    vt[14] = '{1'b1,16'h0108,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd2,16'd3,1'b0};
    vt[15] = '{1'b1,16'h010C,1'b1,16'h0300, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd2,16'd3,1'b0};
    vt[16] = '{1'b1,16'h0110,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'd2,16'd3,1'b1};
    vt[17] = '{1'b1,16'h0110,1'b0,16'h0000, 1'b1,16'h0100,1'b1,16'h0200,16'h0101, 1'b1,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0100,1'b1,16'h0200,16'd2,16'd4,1'b1};
    vt[18] = '{1'b0,16'h0000,1'b0,16'h0000, 1'b1,16'h0104,1'b0,16'h0555,16'h0105, 1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0104,1'b0,16'h0555,16'd2,16'd5,1'b1};

    s_zero = 1'b0; s_zero16 = 16'h0; s_exv = 1'b0; s_ext = 1'b0;
    s_expc = 16'h0; s_extgt = 16'h0;
    idle();
    rst = 1'b1; s_rst = 1'b1;
    cyc();
    rst = 1'b0; s_rst = 1'b0;

    chk("reset q_empty", 32'(q_empty), 32'd1);
    chk("reset q_full", 32'(q_full), 32'd0);
    chk("reset change_PC", 32'(change_PC), 32'd0);
    chk("reset next_PC", 32'(next_PC), 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset upd_valid", 32'(upd_valid), 32'd0);
    chk("reset counters", {mispredict_cnt, branch_cnt}, 32'd0);
    chk("reset seq_err", 32'(seq_err), 32'd0);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].push, vt[i].pc, vt[i].pt, vt[i].ptgt, vt[i].exv, vt[i].expc,
            vt[i].ext, vt[i].extgt, vt[i].explus);
      cyc();
      chk($sformatf("v%0d q_full", i), 32'(q_full), 32'(vt[i].full));
      chk($sformatf("v%0d q_empty", i), 32'(q_empty), 32'(vt[i].empty));
      chk($sformatf("v%0d change_PC", i), 32'(change_PC), 32'(vt[i].chg));
      chk($sformatf("v%0d next_PC", i), 32'(next_PC), 32'(vt[i].npc));
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(vt[i].fl));
      chk($sformatf("v%0d upd_valid", i), 32'(upd_valid), 32'(vt[i].uv));
      chk($sformatf("v%0d upd_pc", i), 32'(upd_pc), 32'(vt[i].upc));
      chk($sformatf("v%0d upd_taken", i), 32'(upd_taken), 32'(vt[i].ut));
      chk($sformatf("v%0d upd_target", i), 32'(upd_target), 32'(vt[i].utgt));
      chk($sformatf("v%0d mispredict_cnt", i), 32'(mispredict_cnt), 32'(vt[i].mc));
      chk($sformatf("v%0d branch_cnt", i), 32'(branch_cnt), 32'(vt[i].bc));
      chk($sformatf("v%0d seq_err", i), 32'(seq_err), 32'(vt[i].serr));
    end

    // Head is {0x108, not taken}; actual taken -> redirect, then reset in DRAIN
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0108, 1'b1, 16'h0400, 16'h0109);
    cyc();
    chk("A change_PC", 32'(change_PC), 32'd1);
    chk("A next_PC", 32'(next_PC), 32'h0400);
    chk("A mispredict_cnt", 32'(mispredict_cnt), 32'd3);
    idle();
    cyc();
    chk("A drain flush", 32'(flush), 32'd1);
    chk("A drain change_PC", 32'(change_PC), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("A rst flush", 32'(flush), 32'd0);
    chk("A rst q_empty", 32'(q_empty), 32'd1);
    chk("A rst counters", {mispredict_cnt, branch_cnt}, 32'd0);
    chk("A rst seq_err", 32'(seq_err), 32'd0);
    chk("A rst upd_valid", 32'(upd_valid), 32'd0);

    // PC mismatch against head 0x0010
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    cyc();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0099, 1'b0, 16'h0000, 16'h009A);
    cyc();
    chk("B seq_err", 32'(seq_err), 32'd1);
    chk("B change_PC", 32'(change_PC), 32'd1);
    chk("B next_PC", 32'(next_PC), 32'h009A);
    chk("B upd_pc", 32'(upd_pc), 32'h0099);
    chk("B counters", {mispredict_cnt, branch_cnt}, {16'd1, 16'd1});
    idle();
    cyc();
    cyc();
    chk("B flush done", 32'(flush), 32'd0);
    chk("B q_empty", 32'(q_empty), 32'd1);

    // Empty queue: not-taken resolves correctly, taken is a miss
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0201);
    cyc();
    chk("C nt change_PC", 32'(change_PC), 32'd0);
    chk("C nt upd_valid", 32'(upd_valid), 32'd1);
    chk("C nt counters", {mispredict_cnt, branch_cnt}, {16'd1, 16'd2});
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0200, 1'b1, 16'h0100, 16'h0201);
    cyc();
    chk("C tk change_PC", 32'(change_PC), 32'd1);
    chk("C tk next_PC", 32'(next_PC), 32'h0100);
    chk("C tk upd_valid", 32'(upd_valid), 32'd1);
    chk("C tk upd_target", 32'(upd_target), 32'h0100);
    chk("C tk counters", {mispredict_cnt, branch_cnt}, {16'd2, 16'd3});
    idle();
    cyc();
    cyc();

    // Saturation on 3-bit counters, FLUSH_CYCLES=1 returns straight to IDLE
    for (int k = 0; k < 10; k++) begin
      s_exv = 1'b1; s_expc = 16'h0300; s_ext = 1'b1; s_extgt = 16'h0100;
      cyc();
      chk($sformatf("D%0d change_PC", k), 32'(s_chg), 32'd1);
      s_exv = 1'b0;
      cyc();
      chk($sformatf("D%0d flush", k), 32'(s_flush), 32'd0);
    end
    chk("D mispredict_cnt sat", 32'(s_mc), 32'd7);
    chk("D branch_cnt sat", 32'(s_bc), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
